ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Boot-time loader between vscpu and block_ram. Assembles a byte stream into 32-bit words and
//  writes them to RAM from a base address while holding the CPU in reset. After a completed
//  load, it passes the CPU write port through to RAM unchanged. RAM read data does not pass
//  through this block.
// PARAMETERS
//  ADDR_W  14  RAM word-address width
//  DATA_W  32  RAM word width; must be a multiple of 8 (BPW = DATA_W/8 bytes per word)
// PORTS
//  clk         in   1       system clock, single domain
//  rst         in   1       synchronous, active-high reset
//  start       in   1       one-cycle load request; honoured in IDLE/DONE only
//  abort       in   1       cancel the load in progress
//  load_base   in   ADDR_W  first word address, sampled on start
//  load_words  in   ADDR_W+1  number of words to load (0..2^ADDR_W), sampled on start
//  byte_valid  in   1       stream byte valid
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts a byte this cycle
//  cpu_we      in   1       CPU write_enable
//  cpu_addr    in   ADDR_W  CPU addr_to_ram
//  cpu_wdata   in   DATA_W  CPU data_to_ram
//  ram_we      out  1       to block_ram write_en
//  ram_addr    out  ADDR_W  to block_ram addr
//  ram_wdata   out  DATA_W  to block_ram data_in
//  cpu_hold    out  1       ORed into the CPU reset by top; high = CPU held
//  busy        out  1       high in COLLECT/WRITE
//  done        out  1       high in DONE
//  words_done  out  ADDR_W+1  words written by the current/last load
// BEHAVIOUR
//  Reset: state=IDLE; byte_cnt, words_done, assembly reg = 0; byte_ready=0, busy=0, done=0,
//    cpu_hold=1, ram_we=0, ram_addr=0, ram_wdata=0.
//  FSM states: IDLE, COLLECT, WRITE, DONE. cpu_hold = (state != DONE): the CPU runs only
//    after a completed load.
//  IDLE/DONE + start:
//    - load_words==0 -> DONE, words_done=0.
//    - otherwise latch base and count, clear byte_cnt and words_done, go to COLLECT next cycle.
//  Bus ownership:
//    - DONE: ram_we/ram_addr/ram_wdata = cpu_* (combinational pass-through).
//    - Other states: the loader drives the bus; cpu_we is ignored. ram_we=1 only in WRITE.
//    - DONE + start: the pass-through stops the next cycle.
//  COLLECT:
//    - byte_ready=1; a byte transfers on byte_valid & byte_ready.
//    - Little-endian packing: byte k of a word goes to bits [8k+7:8k].
//    - When byte BPW-1 transfers, go to WRITE next cycle. byte_valid=0 stalls indefinitely.
//  WRITE (exactly 1 cycle):
//    - byte_ready=0; ram_we=1; ram_addr=cur_addr; ram_wdata=assembled word.
//    - Next: cur_addr+1 (mod 2^ADDR_W, so base 0x3FFF wraps to 0x0000); words_done+1.
//    - Go to DONE if this was the last word, else to COLLECT.
//    - Write-to-next-byte_ready turnaround is 1 cycle. Minimum per word: BPW+1 cycles.
//  abort (priority over start and byte transfer):
//    - In COLLECT/WRITE: go to IDLE next cycle; the partial word is discarded.
//    - In WRITE: the write still completes that cycle.
//    - words_done keeps its count. cpu_hold stays 1.
//    - In IDLE/DONE: no effect.
//  start while busy: ignored. rst mid-load: immediate return to reset values; RAM contents
//    already written are untouched.
// TESTING
//  T1 reset -> cpu_hold=1, ram_we=0, byte_ready=0, done=0
//  T2 base=0x0010, words=2, bytes 11 22 33 44 55 66 77 88 back-to-back
//       -> writes 0x44332211@0x0010 and 0x88776655@0x0011, each ram_we 1 cycle;
//          done=1, cpu_hold=0, words_done=2
//  T3 after T2, cpu_we=1, cpu_addr=0x0100, cpu_wdata=0xDEADBEEF
//       -> ram_* mirror cpu_* in the same cycle
//  T4 base=0x3FFF, words=2 -> second word written at 0x0000; no write at 0x4000 alias
//  T5 abort after 2 bytes of word 1 -> no ram_we; IDLE next cycle; cpu_hold=1; words_done=0
//  T6 words=0 start -> DONE after 1 cycle, no writes
//     start during COLLECT -> ignored
//     byte_valid gaps of 3 cycles -> same data as T2

Source files
------------

// File: rtl/ram_loader.sv
// Boot-time loader: packs a byte stream little-endian into RAM words written
// from a base address while the CPU is held in reset, then hands the RAM write
// port to the CPU once a load has completed.
//
// Byte stream handshake: a byte transfers on a rising clk edge where
// byte_valid and byte_ready are both high; byte_ready does not depend on
// byte_valid, and byte_valid may stay low for any number of cycles.
module ram_loader #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_words,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_done,
   output logic [1:0]        state_dbg
);

   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W:0]     total_words;
   logic [CNT_W-1:0]    byte_cnt;
   logic [DATA_W-1:0]   asm_word;
   logic                xfer;
   logic                last_byte;
   logic                last_word;

   assign xfer      = byte_valid && byte_ready;
   assign last_byte = (byte_cnt == CNT_W'(BPW - 1));
   assign last_word = ((words_done + 1'b1) == total_words);

   assign byte_ready = (state == COLLECT);
   assign busy       = (state == COLLECT) || (state == WRITE);
   assign done       = (state == DONE);
   assign cpu_hold   = (state != DONE);
   assign state_dbg  = state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; abort wins over everything while a load is running.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = (load_words == '0) ? DONE : COLLECT;
         end
         COLLECT: begin
            if (abort)                  state_nxt = IDLE;
            else if (xfer && last_byte) state_nxt = WRITE;
         end
         WRITE: begin
            if (abort)          state_nxt = IDLE;
            else if (last_word) state_nxt = DONE;
            else                state_nxt = COLLECT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Load parameters, byte assembly and word progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr    <= '0;
         total_words <= '0;
         byte_cnt    <= '0;
         asm_word    <= '0;
         words_done  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cur_addr    <= load_base;
                  total_words <= load_words;
                  byte_cnt    <= '0;
                  words_done  <= '0;
               end
            end
            COLLECT: begin
               if (!abort && xfer) begin
                  asm_word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                  byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
               end
            end
            WRITE: begin
               // The write happens this cycle even under abort, so it is counted.
               cur_addr   <= cur_addr + 1'b1;
               words_done <= words_done + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // RAM write port: loader owns it until DONE, then it mirrors the CPU.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         WRITE: begin
            ram_we    = 1'b1;
            ram_addr  = cur_addr;
            ram_wdata = asm_word;
         end
         DONE: begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: loader writes are checked against a queue of
// expected {addr, data} pairs; status outputs are checked at step boundaries.
module tb_ram_loader;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int QW     = ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] load_base;
   logic [ADDR_W:0]   load_words;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   words_done;
   logic [1:0]        state_dbg;

   logic [QW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .load_base(load_base), .load_words(load_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .words_done(words_done), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every loader-owned write must match the head of the queue
   always @(negedge clk) begin
      if (!rst && ram_we && !done) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write observed=%0h_%0h expected=none", ram_addr, ram_wdata);
         end
         if (exp_q.size() != 0) begin
            logic [QW-1:0] e;
            e = exp_q.pop_front();
            check("write", {ram_addr, ram_wdata}, e);
         end
      end
   end

   task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] words);
      start = 1'b1; load_base = base; load_words = words;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1; byte_data = b;
      t = 0;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("byte_ready_timeout", byte_ready, 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] w);
      exp_q.push_back({a, w});
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      check(tag, done, 1);
   endtask

   initial begin
      logic [31:0] w1, w2;
      rst = 1'b1; start = 1'b0; abort = 1'b0; load_base = '0; load_words = '0;
      byte_valid = 1'b0; byte_data = '0;
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(negedge clk);

      // T1 reset values
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_ram_we", ram_we, 0);
      check("rst_byte_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_words_done", words_done, 0);
      rst = 1'b0;
      @(negedge clk);

      // T2 two words back to back
      expect_write(14'h0010, 32'h44332211);
      expect_write(14'h0011, 32'h88776655);
      do_start(14'h0010, 15'd2);
      check("t2_busy", busy, 1);
      send_word(32'h44332211, 0);
      send_word(32'h88776655, 0);
      wait_done("t2_done");
      check("t2_cpu_hold", cpu_hold, 0);
      check("t2_words_done", words_done, 2);
      check("t2_q_empty", exp_q.size(), 0);

      // T3 CPU pass-through in DONE
      cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 32'hDEADBEEF;
      #1;
      check("t3_ram_we", ram_we, 1);
      check("t3_ram_addr", ram_addr, 14'h0100);
      check("t3_ram_wdata", ram_wdata, 32'hDEADBEEF);
      cpu_we = 1'b0;
      #1;
      check("t3_ram_we_off", ram_we, 0);

      // T4 address wrap; pass-through stops the cycle after start
      w1 = $urandom_range(32'hFFFF_FFFF, 0);
      w2 = $urandom_range(32'hFFFF_FFFF, 0);
      expect_write(14'h3FFF, w1);
      expect_write(14'h0000, w2);
      cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 32'h12345678;
      do_start(14'h3FFF, 15'd2);
      check("t4_passthru_stop", ram_we, 0);
      check("t4_cpu_hold", cpu_hold, 1);
      cpu_we = 1'b0;
      send_word(w1, 0);
      send_word(w2, 0);
      wait_done("t4_done");
      check("t4_words_done", words_done, 2);
      check("t4_q_empty", exp_q.size(), 0);

      // T5 abort after 2 bytes of the first word
      do_start(14'h0020, 15'd3);
      send_byte(8'hA1, 0);
      send_byte(8'hA2, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_state_idle", state_dbg, 0);
      check("t5_busy", busy, 0);
      check("t5_cpu_hold", cpu_hold, 1);
      check("t5_words_done", words_done, 0);
      check("t5_byte_ready", byte_ready, 0);
      repeat (3) @(negedge clk);
      check("t5_q_empty", exp_q.size(), 0);

      // T6a zero-word load goes straight to DONE
      do_start(14'h0030, 15'd0);
      check("t6a_done", done, 1);
      check("t6a_words_done", words_done, 0);
      check("t6a_cpu_hold", cpu_hold, 0);

      // T6b start during COLLECT is ignored
      expect_write(14'h0040, 32'hCAFEF00D);
      do_start(14'h0040, 15'd1);
      send_byte(8'h0D, 0);
      do_start(14'h0050, 15'd5);
      check("t6b_still_busy", busy, 1);
      send_byte(8'hF0, 0);
      send_byte(8'hFE, 0);
      send_byte(8'hCA, 0);
      wait_done("t6b_done");
      check("t6b_words_done", words_done, 1);
      check("t6b_q_empty", exp_q.size(), 0);

      // T6c gaps of 3 idle cycles between bytes
      expect_write(14'h0010, 32'h44332211);
      expect_write(14'h0011, 32'h88776655);
      do_start(14'h0010, 15'd2);
      send_word(32'h44332211, 3);
      send_word(32'h88776655, 3);
      wait_done("t6c_done");
      check("t6c_words_done", words_done, 2);
      check("t6c_q_empty", exp_q.size(), 0);

      // T7 reset in the middle of a load
      do_start(14'h0060, 15'd2);
      send_byte(8'h55, 0);
      rst = 1'b1;
      @(negedge clk);
      check("t7_cpu_hold", cpu_hold, 1);
      check("t7_busy", busy, 0);
      check("t7_words_done", words_done, 0);
      check("t7_ram_we", ram_we, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
